// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
//   SPI slave front end for the PWM peripheral. SPI mode 0 (CPOL=0, CPHA=0).
//   sclk, cs_n and mosi are oversampled in the clk domain. Each frame is a
//   command byte followed by one or more data bytes. The block issues
//   single-cycle read/write strobes to the register file. On a read frame it
//   shifts the register read data back out on miso in the same frame.
//   The sclk frequency must not exceed f_clk/8.
//
//   Command byte: bit7 = 1 for write, 0 for read; bit6 is reserved and
//   ignored; bits[5:0] = register address.
//
//   Optional feature: define SPI_ADDR_AUTOINC_EN to allow several data bytes
//   per frame. With it defined, addr increments (and wraps) after each data
//   byte and the FSM stays in DATA. Without it, one data byte is accepted per
//   frame and any further bytes are ignored until cs_n rises.
//
// Ports
//   clk, rst_n   peripheral clock; asynchronous active-low reset
//   sclk         SPI clock (asynchronous to clk)
//   cs_n         SPI chip select, active-low
//   mosi         SPI data in, MSB first
//   miso         SPI data out, MSB first; 0 when not selected
//   read         one-clk read strobe
//   write        one-clk write strobe
//   addr         register address, held until the next command
//   data_read    register read data (combinational from the register file)
//   data_write   register write data, held until the next write
//   frame_err    one-clk pulse when a frame is aborted mid-byte
module spi_cmd_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write,
  output logic              frame_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [DATA_W-1:0]   tx;
  logic                rd_frame, rd_frame_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_write_nxt;
  logic                read_nxt, write_nxt, frame_err_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, sclk_d, cs_s, mosi_s;
  logic                   rise, fall, last_bit, tx_shift;
  logic [DATA_W-1:0]      rx_byte;

  // Synchronizers. cs_n resets to deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_d;
  assign fall     = ~sclk_s & sclk_d;
  assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign rx_byte  = {shreg[DATA_W-2:0], mosi_s};

  // The fall that follows the last rise of a byte leaves tx alone. This keeps
  // the first bit of a freshly loaded byte on miso until the master samples it.
  assign tx_shift = (state == DATA) && fall && (bit_cnt != '0);

  // While read is high, miso shows the register data directly. tx only holds
  // that data from the next cycle onwards.
  assign miso = (state == DATA && rd_frame && !cs_s)
              ? (read ? data_read[DATA_W-1] : tx[DATA_W-1])
              : 1'b0;

  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    rd_frame_nxt   = rd_frame;
    addr_nxt       = addr;
    data_write_nxt = data_write;
    read_nxt       = 1'b0;
    write_nxt      = 1'b0;
    frame_err_nxt  = 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
    // A write keeps its address for the duration of the strobe, then moves on.
    if (write) addr_nxt = addr + 1'b1;
`endif
    if (cs_s) begin
      // Deselect takes priority over any edge seen in the same cycle.
      state_nxt     = IDLE;
      bit_cnt_nxt   = '0;
      frame_err_nxt = (bit_cnt != '0);
    end else begin
      case (state)
        IDLE: begin
          state_nxt   = CMD;
          bit_cnt_nxt = '0;
        end
        CMD: begin
          if (rise) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (last_bit) begin
              bit_cnt_nxt  = '0;
              addr_nxt     = rx_byte[ADDR_W-1:0];
              rd_frame_nxt = ~rx_byte[DATA_W-1];
              read_nxt     = ~rx_byte[DATA_W-1];
              state_nxt    = DATA;
            end
          end
        end
        DATA: begin
          if (rise) begin
            shreg_nxt   = rx_byte;
            bit_cnt_nxt = bit_cnt + 1'b1;
            if (last_bit) begin
              bit_cnt_nxt = '0;
              if (!rd_frame) begin
                write_nxt      = 1'b1;
                data_write_nxt = rx_byte;
              end
`ifdef SPI_ADDR_AUTOINC_EN
              else begin
                // A read frame fetches the next address right away, so the
                // next byte can be reloaded before its first rise.
                read_nxt = 1'b1;
                addr_nxt = addr + 1'b1;
              end
`else
              state_nxt = DONE;
`endif
            end
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rd_frame   <= 1'b0;
      addr       <= '0;
      data_write <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      frame_err  <= 1'b0;
      tx         <= '0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      rd_frame   <= rd_frame_nxt;
      addr       <= addr_nxt;
      data_write <= data_write_nxt;
      read       <= read_nxt;
      write      <= write_nxt;
      frame_err  <= frame_err_nxt;
      if (read)
        tx <= data_read;
      else if (tx_shift)
        tx <= {tx[DATA_W-2:0], 1'b0};
    end
  end

endmodule
